// File: rtl/calc_display_ctrl_pkg.sv
// Shared types and constants for the calculator display controller.
package calc_display_ctrl_pkg;

  // Width of one BCD digit, number of digits and the binary magnitude width.
  localparam int BCD_W      = 4;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_TOT    = BCD_W * BCD_DIGITS;
  localparam int MAG_W      = 9;

  // Display codes beyond the decimal digits 0..9.
  localparam logic [3:0] DIG_MINUS = 4'd10;
  localparam logic [3:0] DIG_BLANK = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2
  } state_t;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal place.
  function automatic logic [BCD_TOT-1:0] bcd_adjust(input logic [BCD_TOT-1:0] v);
    logic [BCD_TOT-1:0] r;
    r = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r[i*BCD_W +: BCD_W] >= 4'd5)
        r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_display_ctrl_if.sv
// Operand/handshake and display bus of the calculator display controller.
interface calc_display_ctrl_if;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       sel;
  logic       busy;
  logic       done;
  logic [3:0] digit;
  logic [3:0] an;

  // The requester drives operands and start; the controller drives the rest.
  modport master (output start, A, B, sel, input busy, done, digit, an);
  modport slave  (input start, A, B, sel, output busy, done, digit, an);
endinterface

// File: rtl/calc_display_ctrl_disp_scan.sv
// Multiplexed display scanner: prescaler, 2-bit scan index and anode decode.
// Index 0/1/2/3 selects units/tens/hundreds/sign; anodes are active-low.
module disp_scan #(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  input  logic [3:0] hund,
  input  logic [3:0] sign,
  output logic [3:0] digit,
  output logic [3:0] an
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [1:0]       idx_next;
  logic             wrap;
  logic [3:0]       digit_next;
  logic [3:0]       an_next;

  assign wrap     = (cnt == CNT_W'(CLK_DIV - 1));
  assign idx_next = wrap ? idx + 2'd1 : idx;

  // Select the code and anode for the position that will be active next cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    digit_next = units;
    an_next    = 4'b1111 ^ (4'b0001 << idx_next);
    case (idx_next)
      2'd0:    digit_next = units;
      2'd1:    digit_next = tens;
      2'd2:    digit_next = hund;
      default: digit_next = sign;
    endcase
  end

  // Prescaler, scan index and the registered digit/anode pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      digit <= 4'd0;
      an    <= 4'b1110;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      cnt   <= wrap ? '0 : cnt + CNT_W'(1);
      idx   <= idx_next;
      digit <= digit_next;
      an    <= an_next;
    end
  end

endmodule

// File: rtl/calc_display_ctrl.sv
// Calculator display controller: captures two 8-bit operands, adds or
// subtracts them, converts the magnitude to BCD with a sequential
// shift-add-3 and shows sign/hundreds/tens/units on a scanned display.
module calc_display_ctrl
  import calc_display_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst,
  calc_display_ctrl_if.slave bus
);

  localparam logic [3:0] LAST_BIT = 4'(MAG_W - 1);

  state_t             state;
  state_t             state_next;

  logic [7:0]         a_q;
  logic [7:0]         b_q;
  logic               sel_q;
  logic               sign_q;
  logic [MAG_W-1:0]   bin_q;
  logic [BCD_TOT-1:0] bcd_q;
  logic [3:0]         bit_cnt;
  logic               done_q;

  logic [MAG_W-1:0]   mag_calc;
  logic               sign_calc;
  logic [BCD_TOT-1:0] bcd_adj;
  logic [BCD_TOT-1:0] bcd_step;
  logic [3:0]         step_h;
  logic [3:0]         step_t;
  logic [3:0]         step_u;
  logic               last_step;

  logic [3:0]         disp_units;
  logic [3:0]         disp_tens;
  logic [3:0]         disp_hund;
  logic [3:0]         disp_sign;

  // Signed result as sign + magnitude; subtraction always yields |A-B|.
  always_comb begin
    mag_calc  = {1'b0, a_q} + {1'b0, b_q};
    sign_calc = 1'b0;
    if (sel_q) begin
      if (a_q >= b_q) begin
        mag_calc = {1'b0, a_q - b_q};
      end else begin
        mag_calc  = {1'b0, b_q - a_q};
        sign_calc = 1'b1;
      end
    end
  end

  // One double-dabble step: correct the nibbles, then shift in the next bit.
  assign bcd_adj   = bcd_adjust(bcd_q);
  assign bcd_step  = (bcd_adj << 1) | BCD_TOT'(bin_q[MAG_W-1]);
  assign step_h    = bcd_step[2*BCD_W +: BCD_W];
  assign step_t    = bcd_step[BCD_W +: BCD_W];
  assign step_u    = bcd_step[0 +: BCD_W];
  assign last_step = (state == CONV) && (bit_cnt == LAST_BIT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state and busy.
  always_comb begin
    state_next = state;
    bus.busy   = (state != IDLE);
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    state_next = CONV;
      CONV:    if (bit_cnt == LAST_BIT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, conversion datapath and display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      sel_q      <= 1'b0;
      sign_q     <= 1'b0;
      bin_q      <= '0;
      bcd_q      <= '0;
      bit_cnt    <= '0;
      done_q     <= 1'b0;
      disp_units <= 4'd0;
      disp_tens  <= DIG_BLANK;
      disp_hund  <= DIG_BLANK;
      disp_sign  <= DIG_BLANK;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q   <= bus.A;
            b_q   <= bus.B;
            sel_q <= bus.sel;
          end
        end
        CALC: begin
          bin_q   <= mag_calc;
          sign_q  <= sign_calc;
          bcd_q   <= '0;
          bit_cnt <= '0;
        end
        CONV: begin
          bcd_q   <= bcd_step;
          bin_q   <= bin_q << 1;
          bit_cnt <= bit_cnt + 4'd1;
          // The final step lands straight in the display so all four
          // positions change on the same edge as done rises.
          if (last_step) begin
            done_q     <= 1'b1;
            disp_units <= step_u;
            disp_tens  <= (step_h == 4'd0 && step_t == 4'd0) ? DIG_BLANK : step_t;
            disp_hund  <= (step_h == 4'd0) ? DIG_BLANK : step_h;
            disp_sign  <= (sign_q && bcd_step != '0) ? DIG_MINUS : DIG_BLANK;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.done = done_q;

  disp_scan #(.CLK_DIV(CLK_DIV)) u_disp_scan (
    .clk   (clk),
    .rst   (rst),
    .units (disp_units),
    .tens  (disp_tens),
    .hund  (disp_hund),
    .sign  (disp_sign),
    .digit (bus.digit),
    .an    (bus.an)
  );

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Bench for calc_display_ctrl: a decimal-arithmetic reference model checked
// against the DUT on every cycle, plus directed cases with literal results.
module tb_calc_display_ctrl;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst;

  calc_display_ctrl_if bus ();

  calc_display_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display code for a position given a decimal result.
  function automatic int code_of(input int mag, input int neg, input int pos);
    case (pos)
      0:       return mag % 10;
      1:       return (mag >= 10) ? (mag / 10) % 10 : 11;
      2:       return (mag >= 100) ? mag / 100 : 11;
      default: return (neg != 0 && mag != 0) ? 10 : 11;
    endcase
  endfunction

  // Reference model: an operation accepted in idle finishes 10 cycles later;
  // the scan position advances once per CLK_DIV cycles since reset.
  int         m_left  = 0;
  bit         m_done  = 1'b0;
  int         m_mag   = 0;
  int         m_neg   = 0;
  int         c_mag   = 0;
  int         c_neg   = 0;
  int         m_cycles = 0;
  bit         m_valid = 1'b0;
  logic [3:0] m_an    = 4'b1110;
  logic [3:0] m_digit = 4'd0;

  always @(posedge clk) begin
    int idx;
    if (rst === 1'b1) begin
      m_left   = 0;
      m_done   = 1'b0;
      m_mag    = 0;
      m_neg    = 0;
      m_cycles = 0;
      m_an     = 4'b1110;
      m_digit  = 4'd0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      m_cycles++;
      idx     = (m_cycles / CLK_DIV) % 4;
      m_an    = 4'b1111 ^ (4'b0001 << idx);
      m_digit = 4'(code_of(m_mag, m_neg, idx));
      m_done  = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_mag  = c_mag;
          m_neg  = c_neg;
        end
      end else if (bus.start === 1'b1) begin
        if (bus.sel) begin
          if (bus.A >= bus.B) begin
            c_mag = int'(bus.A) - int'(bus.B);
            c_neg = 0;
          end else begin
            c_mag = int'(bus.B) - int'(bus.A);
            c_neg = 1;
          end
        end else begin
          c_mag = int'(bus.A) + int'(bus.B);
          c_neg = 0;
        end
        m_left = 10;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy",  bus.busy,  (m_left > 0) ? 1 : 0);
      check("done",  bus.done,  m_done ? 1 : 0);
      check("an",    bus.an,    int'(m_an));
      check("digit", bus.digit, int'(m_digit));
    end
  end

  // One operation; extra start and reset pulses are placed by period number,
  // where period p follows the edge N+p-1 and the start is taken at edge N.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int extra_at, input int rst_at,
                        output int busy_cnt, output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.sel = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int p = 1; p <= 20; p++) begin
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = p;
      end
      bus.start = (p == extra_at);
      if (p == extra_at) bus.A = 8'd99;
      rst = (p == rst_at);
      @(negedge clk);
    end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  // Watch one full scan round and check each position against literals.
  task automatic check_display(input string tag, input int u, input int t, input int h, input int s);
    logic [3:0] seen [4];
    for (int i = 0; i < 4; i++) seen[i] = 4'hF;
    for (int k = 0; k < 4 * CLK_DIV + 1; k++) begin
      case (bus.an)
        4'b1110: seen[0] = bus.digit;
        4'b1101: seen[1] = bus.digit;
        4'b1011: seen[2] = bus.digit;
        4'b0111: seen[3] = bus.digit;
        default: ;
      endcase
      @(negedge clk);
    end
    check({tag, "_units"}, seen[0], u);
    check({tag, "_tens"},  seen[1], t);
    check({tag, "_hund"},  seen[2], h);
    check({tag, "_sign"},  seen[3], s);
    check({tag, "_model_units"}, code_of(m_mag, m_neg, 0), u);
    check({tag, "_model_sign"},  code_of(m_mag, m_neg, 3), s);
  endtask

  initial begin
    int bc, dc, da, first_done, last_done;
    logic [3:0] an_seq [17];

    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  bus.busy,  0);
    check("rst_done",  bus.done,  0);
    check("rst_an",    bus.an,    4'b1110);
    check("rst_digit", bus.digit, 0);
    rst = 1'b0;
    check_display("reset", 0, 11, 11, 11);

    // 200 + 100 = 300
    run_op(8'd200, 8'd100, 1'b0, -1, -1, bc, dc, da);
    check("add300_busy_cycles", bc, 10);
    check("add300_done_count",  dc, 1);
    check("add300_done_period", da, 11);
    check_display("add300", 0, 0, 3, 11);

    // 5 - 7 = -2
    run_op(8'd5, 8'd7, 1'b1, -1, -1, bc, dc, da);
    check("sub_neg_done_period", da, 11);
    check_display("sub_neg2", 2, 11, 11, 10);

    // 7 - 7 = 0, never a minus
    run_op(8'd7, 8'd7, 1'b1, -1, -1, bc, dc, da);
    check_display("sub_zero", 0, 11, 11, 11);

    // 255 + 255 = 510
    run_op(8'd255, 8'd255, 1'b0, -1, -1, bc, dc, da);
    check_display("add510", 0, 1, 5, 11);

    // 0 - 255 = -255
    run_op(8'd0, 8'd255, 1'b1, -1, -1, bc, dc, da);
    check_display("sub_m255", 5, 5, 2, 10);

    // start pulsed again at N+4 with different operands is ignored
    run_op(8'd12, 8'd3, 1'b0, 4, -1, bc, dc, da);
    check("ignore_done_count",  dc, 1);
    check("ignore_done_period", da, 11);
    check_display("ignore", 5, 1, 11, 11);

    // reset at N+6 aborts the conversion
    run_op(8'd50, 8'd8, 1'b1, -1, 6, bc, dc, da);
    check("abort_done_count", dc, 0);
    check_display("abort", 0, 11, 11, 11);

    // next start after the abort completes normally: 9 + 1 = 10
    run_op(8'd9, 8'd1, 1'b0, -1, -1, bc, dc, da);
    check("post_abort_done_period", da, 11);
    check_display("post_abort", 0, 1, 11, 11);

    // start held high: back-to-back operations, done every 11 cycles
    @(negedge clk);
    bus.A = 8'd1; bus.B = 8'd2; bus.sel = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    dc = 0; first_done = -1; last_done = -1;
    for (int p = 1; p <= 33; p++) begin
      if (bus.done === 1'b1) begin
        dc++;
        if (first_done < 0) first_done = p;
        last_done = p;
      end
      if (p == 33) bus.start = 1'b0;
      @(negedge clk);
    end
    check("held_done_count", dc, 3);
    check("held_first_done", first_done, 11);
    check("held_last_done",  last_done, 33);
    check_display("held", 3, 11, 11, 11);

    // reset wins over start on the same edge; then the scan sequence
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.A = 8'd4; bus.B = 8'd4;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    check("rst_prio_busy", bus.busy, 0);
    an_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1110,
               4'b1101, 4'b1101, 4'b1101, 4'b1101,
               4'b1011, 4'b1011, 4'b1011, 4'b1011,
               4'b0111, 4'b0111, 4'b0111, 4'b0111,
               4'b1110};
    for (int k = 0; k < 17; k++) begin
      check($sformatf("scan_an_%0d", k), bus.an, int'(an_seq[k]));
      @(negedge clk);
    end
    check_display("after_rst", 0, 11, 11, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_display_ctrl.md
CALC_DISPLAY_CTRL -- requirements
Module: calc_display_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, meaning clk cycles per display scan step (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to capture operands and compute.
REQ-005 SHALL have port A, input, 8, unsigned operand A, already active-high and bit-ordered.
REQ-006 SHALL have port B, input, 8, unsigned operand B.
REQ-007 SHALL have port sel, input, 1, operation select: 0 = A+B, 1 = A-B.
REQ-008 SHALL have port busy, output, 1, high while a computation is in progress.
REQ-009 SHALL have port done, output, 1, a one-cycle pulse when the new result is displayed.
REQ-010 SHALL have port digit, output, 4, code for the active display: 0-9 decimal, 10 = minus, 11 = blank.
REQ-011 SHALL have port an, output, 4, active-low one-hot anode select.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and CONV.
REQ-013 SHALL capture A, B and sel when start=1 in IDLE at edge N, then go to CALC.
REQ-014 SHALL ignore start while in CALC or CONV, with no queueing.
REQ-015 In CALC (one cycle), the add case SHALL produce a 9-bit magnitude A+B (0..510) with sign=0.
REQ-016 In CALC, the subtract case SHALL produce A-B with sign=0 if A>=B, else B-A with sign=1 (magnitude 0..255).
REQ-017 CONV SHALL run a sequential shift-add-3 binary-to-BCD conversion of the 9-bit magnitude: exactly 9 cycles, one bit per cycle, producing hundreds, tens and units.
REQ-018 busy SHALL be high during cycles N+1..N+10 and low otherwise.
REQ-019 At edge N+11 the FSM SHALL return to IDLE, load the display registers atomically, and assert done=1 for cycle N+11 only.
REQ-020 A new start SHALL be accepted at edge N+11.
REQ-021 Display registers SHALL hold the last result until the next completed conversion.
REQ-022 Leading-zero blanking: hundreds SHALL be blank if 0; tens SHALL be blank if hundreds and tens are both 0; units SHALL always be shown.
REQ-023 The sign position SHALL show 10 if sign=1 and the magnitude is non-zero, else 11; a zero result never shows a minus.
REQ-024 The prescaler SHALL count 0..CLK_DIV-1 and wrap; a wrap SHALL advance the 2-bit scan index modulo 4.
REQ-025 Scan index 0/1/2/3 SHALL map to units/tens/hundreds/sign, with an = 1110/1101/1011/0111 respectively.
REQ-026 digit and an SHALL be registered and change in the same cycle.
REQ-027 Scanning SHALL run continuously and independently of the FSM.

Reset
REQ-028 On rst=1 at an edge, the block SHALL set state=IDLE, busy=0 and done=0.
REQ-029 On reset, the display registers SHALL be set to units=0 and tens, hundreds and sign blank (11).
REQ-030 On reset, the prescaler and scan index SHALL be set to 0, with an=1110 and digit=0.
REQ-031 A reset during CALC or CONV SHALL abort the operation: no done, and the display keeps its reset contents.
REQ-032 rst SHALL have priority over start in the same cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the digit codes DIG_MINUS=10 and DIG_BLANK=11, and the BCD width constants.
REQ-034 The scan prescaler, index and anode decode SHALL be one sub-module, disp_scan, instantiated once.
REQ-035 The 7-segment decoding of digit SHALL stay outside this block.

Verification
REQ-036 Bench case: A=200, B=100, sel=0, start at N -> busy high N+1..N+10; done at N+11; units/tens/hundreds/sign = 0/0/3/blank.
REQ-037 Bench case: A=5, B=7, sel=1 -> units=2, tens blank, hundreds blank, sign=10; A=7, B=7, sel=1 -> units=0, sign blank.
REQ-038 Bench case: A=255, B=255, sel=0 -> 5/1/0 displayed as hundreds=5, tens=1, units=0; A=0, B=255, sel=1 -> sign=10, digits 2,5,5.
REQ-039 Bench case: start pulsed again at N+4 -> ignored, with exactly one done at N+11; start held high continuously -> back-to-back operations with done every 11 cycles.
REQ-040 Bench case: rst at N+6 during CONV -> no done, the display shows reset contents, and the next start completes normally.
REQ-041 Bench case: CLK_DIV=4 -> an steps 1110, 1101, 1011, 0111, 1110 every 4 cycles, with digit matching each position.
